// File: rtl/qsfp_tx_arbiter_if.sv
// Transmit-side bundle between the stream sources, the arbiter and the QSFP TX port.
// slave = arbiter side, master = the sources/sink driving it.
interface qsfp_tx_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 256
);
    localparam int GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_mask;
    logic [NUM_REQ-1:0]        s_valid;
    logic [NUM_REQ*DATA_W-1:0] s_data;
    logic [NUM_REQ-1:0]        s_ready;
    logic                      m_valid;
    logic [DATA_W-1:0]         m_data;
    logic                      m_ready;
    logic                      busy;
    logic [GNT_W-1:0]          cur_grant;

    modport slave (
        input  req_mask, s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, busy, cur_grant
    );

    modport master (
        output req_mask, s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, busy, cur_grant
    );
endinterface

// File: rtl/qsfp_tx_arbiter.sv
// Round-robin burst arbiter sharing the TO_QSFP stream among NUM_REQ sources,
// with a single registered output stage toward the QSFP TX port.
module qsfp_tx_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int DATA_W    = 256,
    parameter int MAX_BURST = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    qsfp_tx_arbiter_if.slave        bus
);
    localparam int GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [GNT_W:0]   NREQ_L = (GNT_W + 1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] LAST_L = CNT_W'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             r_state, w_state_nxt;
    logic [GNT_W-1:0]   r_gnt, r_rr_ptr, w_sel, w_gnt_inc;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               r_m_valid;
    logic [DATA_W-1:0]  r_m_data;
    logic [NUM_REQ-1:0] w_elig, w_s_ready;
    logic [DATA_W-1:0]  w_sdata [NUM_REQ];
    logic               w_found, w_rdy, w_accept, w_release, w_gnt_valid, w_gnt_mask;

    assign w_elig = bus.s_valid & bus.req_mask;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) w_sdata[i] = bus.s_data[i*DATA_W +: DATA_W];
    end

    // Walk downward so the candidate closest to rr_ptr is the one left standing.
    always_comb begin
        logic [GNT_W:0] w_idx;
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + (GNT_W + 1)'(k);
            if (w_idx >= NREQ_L) w_idx = w_idx - NREQ_L;
            if (w_elig[w_idx[GNT_W-1:0]]) begin
                w_sel   = w_idx[GNT_W-1:0];
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        logic [GNT_W:0] w_inc;
        w_inc     = {1'b0, r_gnt} + (GNT_W + 1)'(1);
        w_gnt_inc = (w_inc >= NREQ_L) ? '0 : w_inc[GNT_W-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = '0;
        w_rdy       = 1'b0;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        w_gnt_valid = bus.s_valid[r_gnt];
        w_gnt_mask  = bus.req_mask[r_gnt];
        case (r_state)
            IDLE: begin
                if (w_found) w_state_nxt = GRANT;
            end
            GRANT: begin
                // Ready only when the output stage can take a beat this cycle.
                w_rdy            = w_gnt_mask && (!r_m_valid || bus.m_ready);
                w_s_ready[r_gnt] = w_rdy;
                w_accept         = w_gnt_valid && w_rdy;
                w_release        = (w_accept && (r_beat_cnt == LAST_L)) ||
                                   !w_gnt_valid || !w_gnt_mask;
                if (w_release) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_gnt      <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
        end else begin
            if (r_state == IDLE && w_found) begin
                r_gnt      <= w_sel;
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
            if (w_release) r_rr_ptr <= w_gnt_inc;
            // A pending beat drains on its own, whatever the arbitration state.
            if (w_accept) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_sdata[r_gnt];
            end else if (r_m_valid && bus.m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign bus.s_ready   = w_s_ready;
    assign bus.m_valid   = r_m_valid;
    assign bus.m_data    = r_m_data;
    assign bus.busy      = (r_state == GRANT);
    assign bus.cur_grant = r_gnt;
endmodule

// File: tb/tb_qsfp_tx_arbiter.sv
// Directed bench for qsfp_tx_arbiter: cycle table plus burst/fairness/backpressure sequences.
module tb_qsfp_tx_arbiter;
    localparam int NR = 2;
    localparam int DW = 32;
    localparam int MB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qsfp_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    qsfp_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  mask;
        logic [1:0]  sv;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        mr;
        logic [1:0]  e_sr;
        logic        e_mv;
        logic [31:0] e_md;
        logic        e_busy;
        logic        e_g;
    } vec_t;

    vec_t tv [19];

    int total = 0;
    int bad   = 0;

    logic [1:0]  en;
    logic [1:0]  mask;
    int          lim  [2];
    int          sent [2];
    int          rcv  [2];
    bit          rnd;
    bit          hold;
    logic [31:0] hold_md;
    logic        hb [1024];
    logic        hg [1024];
    logic        hmv [1024];
    logic        hsv0 [1024];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        bus.s_valid  = '0;
        bus.s_data   = '0;
        bus.m_ready  = 1'b1;
        bus.req_mask = 2'b11;
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        sent = '{0, 0};
        rcv  = '{0, 0};
        lim  = '{-1, -1};
        hold = 1'b0;
        rnd  = 1'b0;
        mask = 2'b11;
        en   = 2'b00;
    endtask

    // Sources emit {id, sequence}; the sink checks per-source order and hold stability.
    task automatic run(input int n);
        logic [1:0]  sv, sr;
        logic        mr, mv;
        logic [31:0] md;
        int          id;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) sv[i] = en[i] && (lim[i] < 0 || sent[i] < lim[i]);
            bus.s_valid  = sv;
            bus.s_data   = {16'd1, 16'(sent[1]), 16'd0, 16'(sent[0])};
            mr           = rnd ? 1'($urandom_range(1)) : 1'b1;
            bus.m_ready  = mr;
            bus.req_mask = mask;
            #1;
            sr = bus.s_ready;
            mv = bus.m_valid;
            md = bus.m_data;
            if (c < 1024) begin
                hb[c] = bus.busy; hg[c] = bus.cur_grant; hmv[c] = mv; hsv0[c] = sv[0];
            end
            if (hold) begin
                chk("hold_valid", 32'(mv), 32'd1);
                chk("hold_data", md, hold_md);
            end
            if (mv && mr) begin
                id = int'(md[31:16]);
                if (id < NR) begin
                    chk($sformatf("order_r%0d", id), 32'(md[15:0]), 32'(rcv[id]));
                    rcv[id]++;
                end else begin
                    chk("beat_id", 32'(md[31:16]), 32'd0);
                end
            end
            hold    = mv && !mr;
            hold_md = md;
            @(posedge clk);
            for (int i = 0; i < NR; i++) if (sv[i] && sr[i]) sent[i]++;
        end
    endtask

    initial begin
        int  tot, diff, cnt;
        bit  have_last;
        logic lastg;

        bus.s_valid  = '0;
        bus.s_data   = '0;
        bus.m_ready  = 1'b1;
        bus.req_mask = 2'b11;

        //          rst mask   sv     d0      d1      mr    e_sr   mv  e_md    busy g
        tv[0]  = '{1'b0, 2'b11, 2'b00, 32'h0,   32'h0,   1'b1, 2'b00, 1'b0, 32'h0,   1'b0, 1'b0};
        tv[1]  = '{1'b0, 2'b11, 2'b01, 32'h100, 32'h0,   1'b1, 2'b00, 1'b0, 32'h0,   1'b0, 1'b0};
        tv[2]  = '{1'b0, 2'b11, 2'b01, 32'h100, 32'h0,   1'b1, 2'b01, 1'b0, 32'h0,   1'b1, 1'b0};
        tv[3]  = '{1'b0, 2'b11, 2'b01, 32'h101, 32'h0,   1'b1, 2'b01, 1'b1, 32'h100, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 2'b11, 2'b01, 32'h102, 32'h0,   1'b0, 2'b00, 1'b1, 32'h101, 1'b1, 1'b0};
        tv[5]  = '{1'b0, 2'b11, 2'b01, 32'h102, 32'h0,   1'b0, 2'b00, 1'b1, 32'h101, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 2'b11, 2'b01, 32'h102, 32'h0,   1'b1, 2'b01, 1'b1, 32'h101, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 2'b11, 2'b10, 32'h102, 32'h200, 1'b1, 2'b01, 1'b1, 32'h102, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 2'b11, 2'b10, 32'h0,   32'h200, 1'b1, 2'b00, 1'b0, 32'h102, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 2'b11, 2'b10, 32'h0,   32'h200, 1'b1, 2'b10, 1'b0, 32'h102, 1'b1, 1'b1};
        tv[10] = '{1'b0, 2'b01, 2'b10, 32'h0,   32'h201, 1'b0, 2'b00, 1'b1, 32'h200, 1'b1, 1'b1};
        tv[11] = '{1'b0, 2'b01, 2'b10, 32'h0,   32'h201, 1'b0, 2'b00, 1'b1, 32'h200, 1'b0, 1'b1};
        tv[12] = '{1'b0, 2'b01, 2'b10, 32'h0,   32'h201, 1'b1, 2'b00, 1'b1, 32'h200, 1'b0, 1'b1};
        tv[13] = '{1'b0, 2'b01, 2'b10, 32'h0,   32'h201, 1'b1, 2'b00, 1'b0, 32'h200, 1'b0, 1'b1};
        tv[14] = '{1'b0, 2'b11, 2'b10, 32'h0,   32'h201, 1'b1, 2'b00, 1'b0, 32'h200, 1'b0, 1'b1};
        tv[15] = '{1'b0, 2'b11, 2'b10, 32'h0,   32'h201, 1'b1, 2'b10, 1'b0, 32'h200, 1'b1, 1'b1};
        tv[16] = '{1'b1, 2'b11, 2'b11, 32'h104, 32'h202, 1'b0, 2'b00, 1'b1, 32'h201, 1'b1, 1'b1};
        tv[17] = '{1'b0, 2'b11, 2'b11, 32'h104, 32'h202, 1'b0, 2'b00, 1'b0, 32'h0,   1'b0, 1'b0};
        tv[18] = '{1'b0, 2'b11, 2'b11, 32'h104, 32'h202, 1'b1, 2'b01, 1'b0, 32'h0,   1'b1, 1'b0};

        reset_dut();
        for (int r = 0; r < 19; r++) begin
            @(negedge clk);
            rst          = tv[r].rst;
            bus.req_mask = tv[r].mask;
            bus.s_valid  = tv[r].sv;
            bus.s_data   = {tv[r].d1, tv[r].d0};
            bus.m_ready  = tv[r].mr;
            #1;
            chk($sformatf("vec%0d.s_ready", r),   32'(bus.s_ready),   32'(tv[r].e_sr));
            chk($sformatf("vec%0d.m_valid", r),   32'(bus.m_valid),   32'(tv[r].e_mv));
            chk($sformatf("vec%0d.m_data", r),    bus.m_data,         tv[r].e_md);
            chk($sformatf("vec%0d.busy", r),      32'(bus.busy),      32'(tv[r].e_busy));
            chk($sformatf("vec%0d.cur_grant", r), 32'(bus.cur_grant), 32'(tv[r].e_g));
        end

        // Single source, continuous: 16-beat bursts separated by one bubble.
        reset_dut();
        en = 2'b01;
        run(60);
        chk("A_busy_t0", 32'(hb[0]), 32'd0);
        chk("A_busy_t1", 32'(hb[1]), 32'd1);
        chk("A_mv_t0", 32'(hmv[0]), 32'd0);
        chk("A_mv_t1", 32'(hmv[1]), 32'd0);
        for (int c = 2; c < 55; c++)
            chk($sformatf("A_mv_c%0d", c), 32'(hmv[c]), 32'(((c - 2) % 17) != 16));
        chk("A_beats", 32'(rcv[0]), 32'd55);

        // Requester 0 stops after 5 beats; requester 1 follows after one IDLE.
        reset_dut();
        en = 2'b11;
        lim = '{5, -1};
        run(20);
        chk("D_sv0_c5", 32'(hsv0[5]), 32'd1);
        chk("D_sv0_c6", 32'(hsv0[6]), 32'd0);
        chk("D_busy_c6", 32'(hb[6]), 32'd1);
        chk("D_gnt_c6", 32'(hg[6]), 32'd0);
        chk("D_busy_c7", 32'(hb[7]), 32'd0);
        chk("D_busy_c8", 32'(hb[8]), 32'd1);
        chk("D_gnt_c8", 32'(hg[8]), 32'd1);

        // Requester 1 masked off: it must never own the channel.
        reset_dut();
        en = 2'b11;
        mask = 2'b01;
        run(100);
        cnt = 0;
        for (int c = 0; c < 100; c++) if (hb[c] && hg[c]) cnt++;
        chk("E_r1_grant_cycles", 32'(cnt), 32'd0);
        chk("E_r1_beats", 32'(rcv[1]), 32'd0);
        chk("E_r0_progress", 32'(rcv[0] > 80), 32'd1);

        // Random backpressure, then drain: every beat delivered exactly once.
        reset_dut();
        en = 2'b11;
        rnd = 1'b1;
        run(400);
        en = 2'b00;
        rnd = 1'b0;
        run(40);
        chk("C_r0_all", 32'(rcv[0]), 32'(sent[0]));
        chk("C_r1_all", 32'(rcv[1]), 32'(sent[1]));
        chk("C_progress", 32'(rcv[0] > 20 && rcv[1] > 20), 32'd1);

        // Both always valid: alternating grants and burst-limited fairness.
        reset_dut();
        en = 2'b11;
        run(1000);
        tot  = rcv[0] + rcv[1];
        diff = (rcv[0] > rcv[1]) ? rcv[0] - rcv[1] : rcv[1] - rcv[0];
        chk("B_total_range", 32'(tot >= 925 && tot <= 957), 32'd1);
        chk("B_fair_diff", 32'(diff <= 16), 32'd1);
        have_last = 1'b0;
        lastg = 1'b0;
        chk("B_first_gnt", 32'(hg[1]), 32'd0);
        for (int c = 1; c < 1000; c++) begin
            if (hb[c] && !hb[c-1]) begin
                if (have_last) chk($sformatf("B_alt_c%0d", c), 32'(hg[c]), 32'(!lastg));
                lastg = hg[c];
                have_last = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/qsfp_tx_arbiter.md
# qsfp_tx_arbiter

Round-robin arbiter that shares the single 256-bit TO_QSFP AXI4-Stream transmit channel among NUM_REQ requesters, such as the frame generator and future link-control sources. Each grant lasts a bounded burst of up to MAX_BURST beats. The winner's data is driven onto the QSFP side through one registered output stage. The block sits between the transmit sources and the QSFP TX port in the FPGA top-level wrapper, clocked by the same system clock.

## Interface

Parameters:

- NUM_REQ, default 2: number of requesters (2..8).
- DATA_W, default 256: stream data width.
- MAX_BURST, default 16: maximum beats per grant (1..256).

Ports:

- clk  in  1: system clock. All logic is on this edge.
- reset  in  1: synchronous, active-high reset.
- req_mask  in  NUM_REQ: per-requester enable. A bit value of 0 makes that requester ineligible.
- s_valid  in  NUM_REQ: requester valid, one bit per requester.
- s_data  in  NUM_REQ*DATA_W: requester data. Requester i occupies bits [i*DATA_W +: DATA_W].
- s_ready  out  NUM_REQ: requester ready, one bit per requester.
- m_valid  out  1: valid toward TO_QSFP_VALID.
- m_data  out  DATA_W: data toward TO_QSFP_DATA.
- m_ready  in  1: from TO_QSFP_READY.
- busy  out  1: high while in state GRANT.
- cur_grant  out  clog2(NUM_REQ), min 1: index of the current or most recent grant.

## Operation

- States:
  - IDLE: no requester owns the channel.
  - GRANT: requester `gnt` owns the channel.
- Eligibility: requester i is eligible when s_valid[i] && req_mask[i].
- IDLE behaviour:
  - If any requester is eligible, select the first eligible index searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register the selection in gnt, clear beat_cnt, and move to GRANT.
  - No s_ready is asserted while in IDLE.
- GRANT behaviour:
  - s_ready[gnt] = req_mask[gnt] && (!m_valid || m_ready).
  - All other s_ready bits are 0.
- Accepted beat: an accepted beat is a cycle with s_valid[gnt] && s_ready[gnt].
  - s_data[gnt] is loaded into m_data and m_valid is set to 1.
  - beat_cnt increments.
- Output register:
  - If m_valid && m_ready and no new beat is accepted, m_valid is cleared.
  - m_data holds while m_valid && !m_ready.
- Release from GRANT to IDLE; release takes effect on the next edge:
  - (a) A beat is accepted with beat_cnt == MAX_BURST-1.
  - (b) s_valid[gnt] == 0 in a GRANT cycle.
  - (c) req_mask[gnt] == 0 in a GRANT cycle. No beat is accepted in that cycle.
- On release, rr_ptr = (gnt+1) mod NUM_REQ. This gives fairness: the just-served requester has the lowest priority in the next IDLE search.
- Release never drops a beat: any pending m_valid beat continues to be held until m_ready, independent of the state.
- beat_cnt width is clog2(MAX_BURST)+1. It never exceeds MAX_BURST-1 while in GRANT.
- cur_grant = gnt. It retains its value in IDLE.

## Timing

- Reset values: state IDLE, m_valid 0, m_data 0, s_ready all 0, busy 0, cur_grant 0, rr_ptr 0, beat_cnt 0.
- Reset asserted mid-burst: all of the above apply on the next edge, and any pending output beat is discarded.
- Latency from an eligible s_valid rising in IDLE (cycle t):
  - GRANT is entered at t+1, when s_ready is first asserted.
  - m_valid is first seen at t+2.
- Throughput within a grant: 1 beat/cycle while m_ready = 1.
- Ownership switch: exactly one IDLE cycle between consecutive grants, i.e. 1 bubble per MAX_BURST beats.
- Backpressure: while m_valid && !m_ready, s_ready is 0. No beat is lost or duplicated. m_data is stable until the handshake.
- Simultaneous load and drain (m_valid && m_ready with a new beat accepted): m_valid stays 1 and m_data takes the new beat.
- req_mask is sampled combinationally every cycle. Changes take effect in the same cycle's s_ready and eligibility.
- Single-requester case (NUM_REQ = 1 or only one eligible): the same requester is re-granted after each 1-cycle IDLE.

## Test plan

- Reset, then drive s_valid = 2'b01 continuously with m_ready = 1 and MAX_BURST = 16.
  - Required: m_valid first at cycle 2 after the IDLE sample.
  - Required: 16 beats, one IDLE bubble, 16 beats, and so on.
  - Required: data order is preserved.
- Both requesters always valid, counting payloads, 1000 cycles.
  - Required: grants alternate 0,1,0,1.
  - Required: the per-requester beat counts differ by at most 16.
  - Required: total beats equal 1000 × 16/17 ± 16.
- m_ready toggled randomly at 50% with incrementing payloads.
  - Required: the scoreboard sees every beat exactly once, in order.
  - Required: m_data is stable whenever m_valid && !m_ready.
- Requester 0 drops s_valid after 5 beats.
  - Required: release to IDLE on the next edge, and requester 1 is granted one cycle later.
- Clear req_mask[1] mid-grant of requester 1.
  - Required: s_ready[1] drops the same cycle and the pending output beat still drains.
  - Required: while the mask stays 0, requester 1 is never granted.
- Assert reset for 1 cycle mid-burst while m_valid = 1 and m_ready = 0.
  - Required: the next cycle shows m_valid = 0, busy = 0, cur_grant = 0, and arbitration restarts from requester 0.
